// File: rtl/io_ram_pkg.sv
// io_ram_pkg: shared state type, default geometry and range helper for io_ram_dual.
package io_ram_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int IO_RAM_DATA_W = 8;
    localparam int IO_RAM_DEPTH  = 10240;
    localparam int IO_RAM_ADDR_W = 14;
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction
endpackage

// File: rtl/io_ram_port.sv
// io_ram_port: per-port request qualification, range check and registered read/valid/error.
module io_ram_port
    import io_ram_pkg::*;
#(
    parameter int DATA_W = IO_RAM_DATA_W,
    parameter int DEPTH  = IO_RAM_DEPTH,
    parameter int ADDR_W = IO_RAM_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ready_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              wr_ok_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rd_valid_o,
    output logic              error_o
);
    logic              hit, rd_ok;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid_q, valid_d, err_q, err_d;
    assign hit     = in_range(32'(addr_i), 32'(DEPTH));
    assign wr_ok_o = ready_i && wr_i && hit;
    // a write on the same port wins over a simultaneous read
    assign rd_ok   = ready_i && rd_i && !wr_i;
    always_comb begin
        rdata_d = rd_ok ? (hit ? mem_rdata_i : '0) : rdata_q;
        valid_d = rd_ok;
        err_d   = ready_i && (wr_i || rd_i) && !hit;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    assign rdata_o    = rdata_q;
    assign rd_valid_o = valid_q;
    assign error_o    = err_q;
endmodule

// File: rtl/io_ram_dual.sv
// io_ram_dual: true-dual-port I/O RAM with range checks and A-wins write collision arbitration.
// Optional post-reset zeroing sweep enabled by IORAM_CLEAR_EN; otherwise INIT_FILE seeds the array.
module io_ram_dual
    import io_ram_pkg::*;
#(
    parameter int DATA_W    = IO_RAM_DATA_W,
    parameter int DEPTH     = IO_RAM_DEPTH,
    parameter int ADDR_W    = IO_RAM_ADDR_W,
    parameter     INIT_FILE = "MemoryIO.mif"
) (
    input  logic              clk,
    input  logic              reset,
    output logic              Ready,
    input  logic [ADDR_W-1:0] AddressA,
    input  logic [ADDR_W-1:0] AddressB,
    input  logic [DATA_W-1:0] DataWriteA,
    input  logic [DATA_W-1:0] DataWriteB,
    input  logic              WrEnableA,
    input  logic              WrEnableB,
    input  logic              RdEnableA,
    input  logic              RdEnableB,
    output logic [DATA_W-1:0] DataReadA,
    output logic [DATA_W-1:0] DataReadB,
    output logic              RdValidA,
    output logic              RdValidB,
    output logic              ErrorA,
    output logic              ErrorB,
    output logic              Collision
);
`ifdef IORAM_CLEAR_EN
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_q, clr_d;
`else
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];
`endif
    state_t            state_q, state_d;
    logic              ready_q, coll_q, collide;
    logic              wr_ok_a, wr_ok_b, we_a, we_b;
    logic [ADDR_W-1:0] waddr_a;
    logic [DATA_W-1:0] wdata_a;
    io_ram_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
        .clk_i(clk), .rst_i(reset), .ready_i(ready_q), .addr_i(AddressA),
        .wr_i(WrEnableA), .rd_i(RdEnableA), .mem_rdata_i(mem[AddressA]),
        .wr_ok_o(wr_ok_a), .rdata_o(DataReadA), .rd_valid_o(RdValidA), .error_o(ErrorA)
    );
    io_ram_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
        .clk_i(clk), .rst_i(reset), .ready_i(ready_q), .addr_i(AddressB),
        .wr_i(WrEnableB), .rd_i(RdEnableB), .mem_rdata_i(mem[AddressB]),
        .wr_ok_o(wr_ok_b), .rdata_o(DataReadB), .rd_valid_o(RdValidB), .error_o(ErrorB)
    );
    assign collide = wr_ok_a && wr_ok_b && (AddressA == AddressB);
    assign we_b    = wr_ok_b && !collide;
`ifdef IORAM_CLEAR_EN
    // the sweep borrows port A's write path, so the array stays two-ported
    assign we_a    = (state_q == CLEAR) || wr_ok_a;
    assign waddr_a = (state_q == CLEAR) ? clr_q : AddressA;
    assign wdata_a = (state_q == CLEAR) ? '0 : DataWriteA;
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == CLEAR) begin
            clr_d   = clr_q + 1'b1;
            state_d = (clr_q == ADDR_W'(DEPTH - 1)) ? RUN : CLEAR;
        end
    end
`else
    assign we_a    = wr_ok_a;
    assign waddr_a = AddressA;
    assign wdata_a = DataWriteA;
    always_comb begin
        state_d = state_q;
    end
`endif
    always_ff @(posedge clk) begin
        if (we_a) mem[waddr_a] <= wdata_a;
        if (we_b) mem[AddressB] <= DataWriteB;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef IORAM_CLEAR_EN
            state_q <= CLEAR;
            clr_q   <= '0;
`else
            state_q <= RUN;
`endif
            ready_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
`ifdef IORAM_CLEAR_EN
            clr_q   <= clr_d;
`endif
            state_q <= state_d;
            ready_q <= (state_q == RUN);
            coll_q  <= collide;
        end
    end
    assign Ready     = ready_q;
    assign Collision = coll_q;
endmodule

// File: tb/tb_io_ram_dual.sv
// tb_io_ram_dual: scoreboard bench for io_ram_dual; also covers the IORAM_CLEAR_EN build when defined.
module tb_io_ram_dual;
    localparam int DW = 8;
    localparam int DEPTH = 10240;
    localparam int AW = 14;
`ifdef IORAM_CLEAR_EN
    localparam int READY_EDGES = DEPTH + 1;
`else
    localparam int READY_EDGES = 1;
`endif
    typedef struct {
        logic          va, vb, ea, eb, col;
        logic [DW-1:0] da, db;
    } exp_t;
    logic          clk = 1'b0;
    logic          reset;
    logic          Ready;
    logic [AW-1:0] AddressA, AddressB;
    logic [DW-1:0] DataWriteA, DataWriteB, DataReadA, DataReadB;
    logic          WrEnableA, WrEnableB, RdEnableA, RdEnableB;
    logic          RdValidA, RdValidB, ErrorA, ErrorB, Collision;
    int            checks = 0;
    int            errors = 0;
    exp_t          sbq[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] hold_a = '0;
    logic [DW-1:0] hold_b = '0;
    logic          exp_ready = 1'b0;
    logic [DW-1:0] rnd [16];
    io_ram_dual dut (
        .clk(clk), .reset(reset), .Ready(Ready),
        .AddressA(AddressA), .AddressB(AddressB),
        .DataWriteA(DataWriteA), .DataWriteB(DataWriteB),
        .WrEnableA(WrEnableA), .WrEnableB(WrEnableB),
        .RdEnableA(RdEnableA), .RdEnableB(RdEnableB),
        .DataReadA(DataReadA), .DataReadB(DataReadB),
        .RdValidA(RdValidA), .RdValidB(RdValidB),
        .ErrorA(ErrorA), .ErrorB(ErrorB), .Collision(Collision)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic idle();
        WrEnableA = 1'b0; WrEnableB = 1'b0; RdEnableA = 1'b0; RdEnableB = 1'b0;
        AddressA = '0; AddressB = '0; DataWriteA = '0; DataWriteB = '0;
    endtask
    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, 32'(Ready), 0);
        check({tag, "_datA"}, 32'(DataReadA), 0);
        check({tag, "_datB"}, 32'(DataReadB), 0);
        check({tag, "_rdvA"}, 32'(RdValidA), 0);
        check({tag, "_rdvB"}, 32'(RdValidB), 0);
        check({tag, "_errA"}, 32'(ErrorA), 0);
        check({tag, "_errB"}, 32'(ErrorB), 0);
        check({tag, "_coll"}, 32'(Collision), 0);
    endtask
    // drive one cycle of requests, predict its outcome, then compare one edge later
    task automatic op(input logic wa, input int aa, input logic [DW-1:0] da, input logic ra,
                      input logic wb, input int ab, input logic [DW-1:0] db, input logic rb);
        exp_t e;
        logic ha, hb, wa_ok, wb_ok;
        @(negedge clk);
        WrEnableA = wa; AddressA = AW'(aa); DataWriteA = da; RdEnableA = ra;
        WrEnableB = wb; AddressB = AW'(ab); DataWriteB = db; RdEnableB = rb;
        ha = aa < DEPTH;
        hb = ab < DEPTH;
        wa_ok = exp_ready && wa && ha;
        wb_ok = exp_ready && wb && hb;
        e.va = exp_ready && ra && !wa;
        e.vb = exp_ready && rb && !wb;
        e.da = e.va ? (ha ? model[aa] : '0) : hold_a;
        e.db = e.vb ? (hb ? model[ab] : '0) : hold_b;
        e.ea = exp_ready && (wa || ra) && !ha;
        e.eb = exp_ready && (wb || rb) && !hb;
        e.col = wa_ok && wb_ok && (aa == ab);
        sbq.push_back(e);
        hold_a = e.da;
        hold_b = e.db;
        if (wb_ok && !e.col) model[ab] = db;
        if (wa_ok) model[aa] = da;
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("rdvA", 32'(RdValidA), 32'(e.va));
        check("datA", 32'(DataReadA), 32'(e.da));
        check("errA", 32'(ErrorA), 32'(e.ea));
        check("rdvB", 32'(RdValidB), 32'(e.vb));
        check("datB", 32'(DataReadB), 32'(e.db));
        check("errB", 32'(ErrorB), 32'(e.eb));
        check("coll", 32'(Collision), 32'(e.col));
        idle();
    endtask
    task automatic wait_ready(input int start);
        int n;
        n = start;
        while (!Ready && n < 3 * DEPTH) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_edges", 32'(n), 32'(READY_EDGES));
        exp_ready = 1'b1;
`ifdef IORAM_CLEAR_EN
        foreach (model[i]) model[i] = '0;
`endif
    endtask
    task automatic assert_reset(input string tag);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outs(tag);
        exp_ready = 1'b0;
        hold_a = '0;
        hold_b = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask
    initial begin
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("por");
        @(posedge clk);
        #2 reset = 1'b0;
        wait_ready(0);
`ifdef IORAM_CLEAR_EN
        op(0, 0, 0, 1, 0, 5000, 0, 1);
        op(0, 10239, 0, 1, 0, 0, 0, 0);
`endif
        op(1, 0, 8'h3C, 0, 0, 0, 0, 0);
        op(1, 100, 8'h5A, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 100, 0, 1);
        op(1, 7, 8'h11, 0, 0, 0, 0, 0);
        op(1, 7, 8'h22, 0, 0, 7, 0, 1);
        op(0, 0, 0, 0, 0, 7, 0, 1);
        op(1, 300, 8'hAA, 0, 1, 300, 8'hBB, 0);
        op(0, 300, 0, 1, 0, 300, 0, 1);
        op(1, DEPTH, 8'hFF, 0, 0, 0, 0, 0);
        op(0, DEPTH, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 1, 0, 0, 0, 0);
        op(1, 50, 8'h44, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 16383, 8'h12, 1);
        op(0, 0, 0, 0, 0, 16383, 0, 1);
        for (int i = 0; i < 16; i++) rnd[i] = DW'($urandom);
        for (int i = 0; i < 8; i++)
            op(1, 1000 + 2 * i * 613, rnd[2*i], 0, 1, 1000 + (2 * i + 1) * 613, rnd[2*i+1], 0);
        for (int i = 0; i < 16; i++)
            op(0, 1000 + i * 613, 0, 1, 0, 1000 + (15 - i) * 613, 0, 1);
        op(0, 50, 0, 1, 0, 0, 0, 0);
        assert_reset("async");
`ifdef IORAM_CLEAR_EN
        repeat (4000) @(posedge clk);
        assert_reset("midsweep");
`endif
        op(1, 100, 8'h99, 0, 0, 100, 0, 1);
        wait_ready(1);
        op(0, 100, 0, 1, 0, 7, 0, 1);
        op(0, 300, 0, 1, 0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_ram_dual.md
# io_ram_dual

Parametrised dual-port I/O RAM. Serves the CPU memory bus on port A and a peripheral/device engine on port B, sharing one synchronous array. Adds per-port read-valid handshaking, out-of-range detection and same-address write collision arbitration. Adds an optional post-reset clear sweep. Sits in the IOM subsystem in place of the single-port I/O RAM.

## Interface
Parameters:
- DATA_W, 8, data width in bits
- DEPTH, 10240, number of words
- ADDR_W, 14, address width; must satisfy 2**ADDR_W >= DEPTH
- INIT_FILE, "MemoryIO.mif", memory initialisation file; used only when the clear sweep is compiled out

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- Ready  out  1  array accepts requests
- AddressA, AddressB  in  ADDR_W  word address, ports A and B
- DataWriteA, DataWriteB  in  DATA_W  write data
- WrEnableA, WrEnableB  in  1  write request
- RdEnableA, RdEnableB  in  1  read request
- DataReadA, DataReadB  out  DATA_W  read data, registered
- RdValidA, RdValidB  out  1  DataRead updated this cycle
- ErrorA, ErrorB  out  1  out-of-range access pulse
- Collision  out  1  same-address dual-write pulse

## Operation
- Request qualification: a port's request is accepted only while Ready=1. Requests while Ready=0 are dropped, with no valid and no error.
- Write and read on the same port in the same cycle: the write is performed and the read is dropped. RdValid stays 0.
- Read: an accepted read latches Memory[Address] into DataRead. DataRead holds its value until the next accepted read on that port.
- Out of range (Address >= DEPTH):
  - A write is ignored.
  - A read returns 0 with RdValid=1.
  - Either case pulses Error for 1 cycle.
- Cross-port read during write, same address, same cycle: the reader gets the old data.
- Both ports write the same in-range address in the same cycle:
  - Port A's data is stored and port B's write is discarded.
  - Collision pulses 1 cycle.
- FSM (io_ram_pkg::state_t):
  - CLEAR: sweep counter writes 0 to addresses 0..DEPTH-1, one per cycle; Ready=0. Moves to RUN after writing DEPTH-1.
  - RUN: Ready=1.
- Reset entry: reset enters CLEAR if the sweep is compiled in, otherwise RUN. Reset asserted mid-sweep restarts the sweep at address 0 after release.
- Array contents are not touched by reset itself.

## Timing
- Reset values: DataReadA/B=0, RdValidA/B=0, ErrorA/B=0, Collision=0, Ready=0, sweep counter=0.
- Read latency is 1 cycle: with request in cycle N, DataRead and RdValid are valid in cycle N+1. RdValid is a 1-cycle pulse per accepted read.
- Back-to-back reads are accepted every cycle, giving full throughput on each port independently.
- Write data is visible to either port's read issued in cycle N+1 or later.
- Error and Collision assert in cycle N+1 for an offending request in cycle N.
- Ready after reset release:
  - With the sweep: rises on the edge after the last clear write, DEPTH+1 edges after release.
  - Without the sweep: rises on the first edge after release.

## Configuration
- Macro: IORAM_CLEAR_EN.
- Defined: CLEAR state and sweep counter are compiled in. Memory is zeroed after every reset and INIT_FILE is not applied.
- Undefined: no sweep logic. The array carries the ram_init_file attribute pointing at INIT_FILE, and the FSM is permanently RUN after reset.

## Structure
- Package io_ram_pkg:
  - state_t enum {CLEAR, RUN}
  - default DATA_W/DEPTH/ADDR_W constants
  - function in_range(addr, depth)
- Sub-module io_ram_port, instantiated twice:
  - request qualification, range check, read register, RdValid/Error pulses
- The array, collision arbitration and FSM stay in io_ram_dual so both ports infer one true-dual-port block RAM.

## Test plan
- Sweep (IORAM_CLEAR_EN): reset for 3 cycles, then release. Ready=0 for 10240 edges and rises on edge 10241. Reads of 0, 5000 and 10239 all return 0x00.
- Basic R/W: A writes 0x5A to 100. B reads 100 in the next cycle. RdValidB=1 one cycle later with DataReadB=0x5A.
- Cross-port: mem[7]=0x11. In the same cycle A writes 0x22 to 7 and B reads 7. DataReadB=0x11; B's read on the next cycle returns 0x22.
- Collision: A writes 0xAA and B writes 0xBB to 300 in the same cycle. Collision=1 for one cycle; a read of 300 returns 0xAA.
- Range: A writes 0xFF to 10240, then reads 10240. ErrorA pulses twice; the read gives DataReadA=0x00 with RdValidA=1. mem[0] is unchanged.
- Mid-sweep reset: assert reset at sweep address 4000. Outputs return to reset values immediately (asynchronously). After release, the sweep restarts and Ready rises 10241 edges later.
